// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store stage with a req/gnt/rvalid data-memory port.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing alignment.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              done,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              lsu_err,
  output logic [1:0]        lsu_err_cause,
  output logic [2:0]        dbg_state
);

  localparam int            CW     = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_ERR  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          timed_out;
  logic          lat_we;
  logic [2:0]    lat_f3;
  logic [4:0]    lat_rd;
  logic [1:0]    lat_lane;
  logic [1:0]    pend_cause;

  logic          f3_illegal;
  logic          misalign_trap;
  logic [1:0]    lane;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_val;
  logic          wb_ok;

  // Handshakes: a request transfers on the rising edge where req_valid && req_ready;
  // mem_req is held with stable address/controls until mem_gnt is sampled high, and
  // mem_rvalid is only honoured in WAIT, i.e. at least one cycle after the grant.

  always_comb begin
    f3_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
      3'b100, 3'b101:         f3_illegal = req_we;
      default:                f3_illegal = 1'b1;
    endcase

    // Low address bits below the access size are dropped; with trapping enabled
    // misaligned requests never reach this path, so the masking is harmless there.
    lane = req_addr[1:0];
    if (req_funct3[1:0] == 2'b01) lane[0] = 1'b0;
    else if (req_funct3[1:0] == 2'b10) lane = 2'b00;

    be_calc    = 4'b1111;
    wdata_calc = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << lane;
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {lane[1], 1'b0};
        wdata_calc = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_trap = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_trap = 1'b0;
`endif

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lat_lane)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ;
    endcase
    ld_half  = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    case (lat_f3)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'b0, ld_byte};
      3'b101:  load_val = {16'b0, ld_half};
      default: ;
    endcase
  end

  assign wb_ok     = !lat_we && (lat_rd != 5'd0);
  assign cnt_inc   = cnt + CW'(1);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_inc >= TO_LIM);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_be        <= 4'b0;
      mem_wdata     <= 32'b0;
      done          <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= 5'b0;
      wb_data       <= 32'b0;
      lsu_err       <= 1'b0;
      lsu_err_cause <= 2'b0;
      cnt           <= '0;
      lat_we        <= 1'b0;
      lat_f3        <= 3'b0;
      lat_rd        <= 5'b0;
      lat_lane      <= 2'b0;
      pend_cause    <= 2'b0;
    end else begin
      // Result outputs are one-cycle qualifiers of done; clear them unless set below.
      done          <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= 5'b0;
      wb_data       <= 32'b0;
      lsu_err       <= 1'b0;
      lsu_err_cause <= 2'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_rd    <= req_rd;
            lat_lane  <= lane;
            cnt       <= '0;
            if (f3_illegal) begin
              pend_cause <= 2'b11;
              state      <= S_ERR;
            end else if (misalign_trap) begin
              pend_cause <= 2'b01;
              state      <= S_ERR;
            end else begin
              mem_req   <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_we    <= req_we;
              mem_be    <= be_calc;
              mem_wdata <= wdata_calc;
              state     <= S_REQ;
            end
          end
        end
        S_ERR: begin
          state         <= S_RESP;
          done          <= 1'b1;
          lsu_err       <= 1'b1;
          lsu_err_cause <= pend_cause;
          wb_rd         <= lat_rd;
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= cnt_inc;
            state   <= S_WAIT;
          end else if (timed_out) begin
            mem_req       <= 1'b0;
            state         <= S_RESP;
            done          <= 1'b1;
            lsu_err       <= 1'b1;
            lsu_err_cause <= 2'b10;
            wb_rd         <= lat_rd;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state   <= S_RESP;
            done    <= 1'b1;
            wb_rd   <= lat_rd;
            wb_we   <= wb_ok;
            wb_data <= wb_ok ? load_val : 32'b0;
          end else if (timed_out) begin
            state         <= S_RESP;
            done          <= 1'b1;
            lsu_err       <= 1'b1;
            lsu_err_cause <= 2'b10;
            wb_rd         <= lat_rd;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
